// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: state encodings and tohost constants shared by the run monitor.
package test_monitor_pkg;
    typedef enum logic [2:0] {
        MON_IDLE    = 3'd0,
        MON_RUN     = 3'd1,
        MON_PASS    = 3'd2,
        MON_FAIL    = 3'd3,
        MON_TIMEOUT = 3'd4,
        MON_HANG    = 3'd5
    } mon_state_t;
    localparam int TOHOST_PASS = 1;
endpackage

// File: rtl/test_monitor_trace.sv
// test_monitor_trace: circular history of retired PCs, read relative to the newest entry.
module test_monitor_trace #(
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          we,
    input  logic [31:0]   pc,
    input  logic [IW-1:0] idx,
    output logic [31:0]   rd_pc
);
    logic [31:0]   mem [DEPTH];
    logic [IW-1:0] wp;
    logic [IW-1:0] rp;
    // Write pointer wraps naturally; clearing every entry makes unwritten slots read 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wp] <= pc;
            wp      <= wp + 1'b1;
        end
    end
    // Index 0 is the most recent write, one slot behind the write pointer.
    always_comb begin
        rp    = wp - IW'(1) - idx;
        rd_pc = mem[rp];
    end
endmodule

// File: rtl/test_monitor.sv
// test_monitor: classifies a core run as PASS, FAIL, TIMEOUT or HANG from tohost writes, retires and stalls.
// Optional PC trace buffer is built when TEST_MONITOR_TRACE_EN is defined.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CYC_W       = 32,
    parameter int TIMEOUT     = 100,
    parameter int STALL_LIMIT = 16,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           tohost_we,
    input  logic [DATA_W-1:0]              tohost_wdata,
    input  logic                           retire,
    input  logic [31:0]                    retire_pc,
    input  logic                           stall,
`ifdef TEST_MONITOR_TRACE_EN
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [31:0]                    trace_pc,
`endif
    output logic                           running,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timed_out,
    output logic                           hang,
    output logic [DATA_W-2:0]              fail_code,
    output logic [CYC_W-1:0]               cycles,
    output logic [CYC_W-1:0]               retired
);
    localparam logic [CYC_W-1:0]  TO_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [CYC_W-1:0]  SL_LAST = CYC_W'(STALL_LIMIT - 1);
    localparam logic [DATA_W-1:0] PASS_W  = DATA_W'(TOHOST_PASS);
    mon_state_t       state;
    mon_state_t       state_nx;
    logic [CYC_W-1:0] stall_cnt;
    logic             in_run;
    assign in_run    = state == MON_RUN;
    assign running   = in_run;
    assign pass      = state == MON_PASS;
    assign fail      = state == MON_FAIL;
    assign timed_out = state == MON_TIMEOUT;
    assign hang      = state == MON_HANG;
    assign done      = pass | fail | timed_out | hang;
    // State register; terminal states hold until start or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MON_IDLE;
        else        state <= state_nx;
    end
    // Start overrides everything; otherwise RUN resolves events in priority order.
    always_comb begin
        state_nx = state;
        if (start) state_nx = MON_RUN;
        else if (in_run) begin
            if (tohost_we && tohost_wdata == PASS_W) state_nx = MON_PASS;
            else if (tohost_we && tohost_wdata != '0) state_nx = MON_FAIL;
            else if (TIMEOUT != 0 && cycles == TO_LAST) state_nx = MON_TIMEOUT;
            else if (STALL_LIMIT != 0 && stall && stall_cnt == SL_LAST) state_nx = MON_HANG;
        end
    end
    // Saturating run statistics and stall-run length; frozen outside RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles    <= '0;
            retired   <= '0;
            stall_cnt <= '0;
        end else if (start) begin
            cycles    <= '0;
            retired   <= '0;
            stall_cnt <= '0;
        end else if (in_run) begin
            cycles    <= cycles + CYC_W'(~&cycles);
            retired   <= retired + CYC_W'(retire && ~&retired);
            stall_cnt <= stall ? stall_cnt + CYC_W'(~&stall_cnt) : '0;
        end
    end
    // Fail code is the tohost payload without its terminate bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               fail_code <= '0;
        else if (start)                           fail_code <= '0;
        else if (in_run && state_nx == MON_FAIL)  fail_code <= tohost_wdata[DATA_W-1:1];
    end
`ifdef TEST_MONITOR_TRACE_EN
    test_monitor_trace #(.DEPTH(TRACE_DEPTH)) u_trace (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .we    (in_run && retire && !start),
        .pc    (retire_pc),
        .idx   (trace_idx),
        .rd_pc (trace_pc)
    );
`endif
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed and randomized checks of the run monitor against a run-outcome model.
module tb_test_monitor;
    localparam int DATA_W = 32, CYC_W = 32, TIMEOUT = 100, STALL_LIMIT = 16, TRACE_DEPTH = 8;
    localparam logic [5:0] S_IDLE = 6'b000000, S_RUN = 6'b100000, S_PASS = 6'b011000,
                           S_FAIL = 6'b010100, S_TO = 6'b010010, S_HANG = 6'b010001;
    localparam int NCYC = 110;
    logic clk = 0, reset = 0, start = 0, tohost_we = 0, retire = 0, stall = 0;
    logic [DATA_W-1:0] tohost_wdata = '0;
    logic [31:0] retire_pc = '0;
    logic running, done, pass, fail, timed_out, hang;
    logic [DATA_W-2:0] fail_code;
    logic [CYC_W-1:0] cycles, retired;
    logic [5:0] st;
`ifdef TEST_MONITOR_TRACE_EN
    logic [2:0] trace_idx = '0;
    logic [31:0] trace_pc;
`endif
    int tests = 0, fails = 0;
    assign st = {running, done, pass, fail, timed_out, hang};
    always #5 clk = ~clk;
    test_monitor #(.DATA_W(DATA_W), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT), .STALL_LIMIT(STALL_LIMIT),
                   .TRACE_DEPTH(TRACE_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .tohost_we(tohost_we), .tohost_wdata(tohost_wdata),
        .retire(retire), .retire_pc(retire_pc), .stall(stall),
`ifdef TEST_MONITOR_TRACE_EN
        .trace_idx(trace_idx), .trace_pc(trace_pc),
`endif
        .running(running), .done(done), .pass(pass), .fail(fail), .timed_out(timed_out), .hang(hang),
        .fail_code(fail_code), .cycles(cycles), .retired(retired));
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start();
        start = 1;
        cyc();
        start = 0;
    endtask
    task automatic test_reset();
        #3;
        tests++;
        if ({st, fail_code, cycles, retired} !== '0) begin
            fails++;
            $display("FAIL reset_init: st=%b code=%0d cyc=%0d ret=%0d, want all 0", st, fail_code, cycles, retired);
        end
        start = 1;
        cyc();
        start = 0;
        reset = 1;
        cyc();
        tests++;
        if (st !== S_IDLE) begin fails++; $display("FAIL start_in_reset: st=%b want %b", st, S_IDLE); end
        do_start();
        repeat (37) cyc();
        tests++;
        if (cycles !== 37) begin fails++; $display("FAIL pre_reset_cycles: got %0d want 37", cycles); end
        #2 reset = 0;
        #1;
        tests++;
        if ({st, cycles, retired} !== '0) begin
            fails++;
            $display("FAIL midrun_reset: st=%b cyc=%0d ret=%0d, want 0", st, cycles, retired);
        end
        cyc();
        reset = 1;
        do_start();
        tests++;
        if (st !== S_RUN || cycles !== 0) begin fails++; $display("FAIL restart: st=%b cyc=%0d want %b/0", st, cycles, S_RUN); end
        repeat (5) cyc();
        tests++;
        if (cycles !== 5) begin fails++; $display("FAIL restart_count: got %0d want 5", cycles); end
    endtask
    task automatic test_pass();
        do_start();
        for (int i = 0; i < 20; i++) begin
            retire = i < 10;
            cyc();
        end
        retire = 0;
        tohost_we = 1;
        tohost_wdata = 1;
        cyc();
        tests++;
        if (st !== S_PASS || retired !== 10 || cycles !== 21) begin
            fails++;
            $display("FAIL pass: st=%b ret=%0d cyc=%0d want %b/10/21", st, retired, cycles, S_PASS);
        end
        tohost_wdata = 32'h7;
        retire = 1;
        repeat (3) cyc();
        tohost_we = 0;
        retire = 0;
        tests++;
        if (st !== S_PASS || retired !== 10 || cycles !== 21) begin
            fails++;
            $display("FAIL pass_sticky: st=%b ret=%0d cyc=%0d want %b/10/21", st, retired, cycles, S_PASS);
        end
    endtask
    task automatic test_fail();
        do_start();
        tohost_we = 1;
        tohost_wdata = 32'h0000000B;
        cyc();
        tests++;
        if (st !== S_FAIL || fail_code !== 5) begin fails++; $display("FAIL fail: st=%b code=%0d want %b/5", st, fail_code, S_FAIL); end
        tohost_wdata = 1;
        cyc();
        tohost_we = 0;
        tests++;
        if (st !== S_FAIL || fail_code !== 5) begin fails++; $display("FAIL fail_sticky: st=%b code=%0d want %b/5", st, fail_code, S_FAIL); end
    endtask
    task automatic test_timeout();
        do_start();
        repeat (TIMEOUT - 1) cyc();
        tests++;
        if (st !== S_RUN) begin fails++; $display("FAIL timeout_early: st=%b want %b", st, S_RUN); end
        cyc();
        tests++;
        if (st !== S_TO || cycles !== TIMEOUT) begin fails++; $display("FAIL timeout: st=%b cyc=%0d want %b/%0d", st, cycles, S_TO, TIMEOUT); end
        repeat (4) cyc();
        tests++;
        if (cycles !== TIMEOUT) begin fails++; $display("FAIL timeout_freeze: cyc=%0d want %0d", cycles, TIMEOUT); end
        do_start();
        repeat (TIMEOUT - 1) cyc();
        tohost_we = 1;
        tohost_wdata = 1;
        cyc();
        tohost_we = 0;
        tests++;
        if (st !== S_PASS || cycles !== TIMEOUT) begin fails++; $display("FAIL pass_vs_timeout: st=%b cyc=%0d want %b/%0d", st, cycles, S_PASS, TIMEOUT); end
    endtask
    task automatic test_hang();
        do_start();
        stall = 1;
        repeat (15) cyc();
        stall = 0;
        cyc();
        stall = 1;
        repeat (15) cyc();
        tests++;
        if (st !== S_RUN) begin fails++; $display("FAIL hang_early: st=%b want %b", st, S_RUN); end
        cyc();
        stall = 0;
        tests++;
        if (st !== S_HANG || cycles !== 32) begin fails++; $display("FAIL hang: st=%b cyc=%0d want %b/32", st, cycles, S_HANG); end
    endtask
    task automatic test_start_priority();
        do_start();
        retire = 1;
        repeat (5) cyc();
        start = 1;
        tohost_we = 1;
        tohost_wdata = 1;
        cyc();
        start = 0;
        retire = 0;
        tests++;
        if (st !== S_RUN || cycles !== 0 || retired !== 0) begin
            fails++;
            $display("FAIL start_vs_pass: st=%b cyc=%0d ret=%0d want %b/0/0", st, cycles, retired, S_RUN);
        end
        cyc();
        tohost_we = 0;
        do_start();
        tests++;
        if (st !== S_RUN || cycles !== 0) begin fails++; $display("FAIL start_from_pass: st=%b cyc=%0d want %b/0", st, cycles, S_RUN); end
    endtask
    task automatic test_random();
        bit s_we [NCYC];
        bit s_ret [NCYC];
        bit s_st [NCYC];
        logic [DATA_W-1:0] s_wd [NCYC];
        for (int r = 0; r < 30; r++) begin
            int sp, wp, k, run, nret;
            logic [5:0] exp_st;
            logic [DATA_W-2:0] exp_code;
            sp = (r % 3 == 0) ? 92 : 25;
            wp = (r % 3 == 1) ? 0 : 3;
            for (int c = 0; c < NCYC; c++) begin
                int pick;
                s_we[c] = $urandom_range(99) < wp;
                s_ret[c] = $urandom_range(1) == 1;
                s_st[c] = $urandom_range(99) < sp;
                pick = $urandom_range(2);
                s_wd[c] = pick == 0 ? 0 : pick == 1 ? 1 : ($urandom | 32'h2);
            end
            k = -1;
            run = 0;
            exp_st = S_RUN;
            exp_code = '0;
            for (int c = 0; c < NCYC && k < 0; c++) begin
                run = s_st[c] ? run + 1 : 0;
                if (s_we[c] && s_wd[c] == 1) begin k = c; exp_st = S_PASS; end
                else if (s_we[c] && s_wd[c] != 0) begin k = c; exp_st = S_FAIL; exp_code = s_wd[c][DATA_W-1:1]; end
                else if (c == TIMEOUT - 1) begin k = c; exp_st = S_TO; end
                else if (run == STALL_LIMIT) begin k = c; exp_st = S_HANG; end
            end
            nret = 0;
            for (int c = 0; c <= k; c++) nret += int'(s_ret[c]);
            do_start();
            for (int c = 0; c < NCYC; c++) begin
                tohost_we = s_we[c];
                tohost_wdata = s_wd[c];
                retire = s_ret[c];
                stall = s_st[c];
                cyc();
            end
            {tohost_we, retire, stall} = '0;
            tests++;
            if (st !== exp_st || cycles !== CYC_W'(k + 1) || retired !== CYC_W'(nret)) begin
                fails++;
                $display("FAIL rand%0d: st=%b cyc=%0d ret=%0d want %b/%0d/%0d", r, st, cycles, retired, exp_st, k + 1, nret);
            end
            if (exp_st == S_FAIL) begin
                tests++;
                if (fail_code !== exp_code) begin fails++; $display("FAIL rand%0d_code: got %0h want %0h", r, fail_code, exp_code); end
            end
        end
    endtask
`ifdef TEST_MONITOR_TRACE_EN
    task automatic test_trace();
        do_start();
        #1;
        tests++;
        if (trace_pc !== 0) begin fails++; $display("FAIL trace_empty: got %0h want 0", trace_pc); end
        for (int i = 0; i < 11; i++) begin
            retire = 1;
            retire_pc = 32'h100 + 32'(4 * i);
            cyc();
        end
        retire = 0;
        for (int i = 0; i < TRACE_DEPTH; i++) begin
            trace_idx = 3'(i);
            #1;
            tests++;
            if (trace_pc !== 32'h128 - 32'(4 * i)) begin fails++; $display("FAIL trace_idx%0d: got %0h want %0h", i, trace_pc, 32'h128 - 32'(4 * i)); end
        end
        tohost_we = 1;
        tohost_wdata = 1;
        cyc();
        tohost_we = 0;
        retire = 1;
        retire_pc = 32'hDEAD0;
        repeat (3) cyc();
        retire = 0;
        trace_idx = 0;
        #1;
        tests++;
        if (trace_pc !== 32'h128) begin fails++; $display("FAIL trace_frozen: got %0h want 128", trace_pc); end
    endtask
`endif
    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_hang();
        test_start_priority();
        test_random();
`ifdef TEST_MONITOR_TRACE_EN
        test_trace();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
